// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit: next-PC source select,
// run/halt state values and the sequential step size.
package pc_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  typedef logic [0:0] pc_state_t;
  localparam pc_state_t ST_RUN    = 1'b0;
  localparam pc_state_t ST_HALTED = 1'b1;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a top pointer plus an occupancy count. A push
// when full overwrites the oldest slot, and both error flags are sticky.
module ras_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             empty_s, full_s, do_pop_s;

  assign empty_s  = (cnt_q == {CW{1'b0}});
  assign full_s   = (cnt_q == CW'(DEPTH));
  assign do_pop_s = pop_i && !empty_s;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (pop_i && empty_s) begin
      unf_d = 1'b1;
    end else begin
      unf_d = unf_q;
    end
    // Push+pop on a live stack swaps the top in place, leaving count alone.
    if (push_i && do_pop_s) begin
      mem_d[ptr_q] = data_i;
    end else if (push_i) begin
      ptr_d        = ptr_q + PW'(1);
      mem_d[ptr_d] = data_i;
      if (full_s) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (do_pop_s) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign top_o       = empty_s ? {WIDTH{1'b0}} : mem_q[ptr_q];
  assign empty_o     = empty_s;
  assign full_o      = full_s;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: RUN/HALTED control, next-PC selection with a
// return-address stack, and a count of retired PC updates.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       RAS_DEPTH    = 4,
  parameter int unsigned       CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 halt,
  input  logic                 resume,
  input  logic                 stall,
  input  logic [1:0]           sel,
  input  logic [WIDTH-1:0]     branch_off,
  input  logic [WIDTH-1:0]     jump_target,
  input  logic [WIDTH-1:0]     reg_target,
  input  logic                 push_ra,
  input  logic                 pop_ra,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     pc_plus4,
  output logic [WIDTH-1:0]     ras_top,
  output logic                 ras_empty,
  output logic                 ras_full,
  output logic                 ras_overflow,
  output logic                 ras_underflow,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired
);

  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [WIDTH-1:0]     pc_plus4_s, target_s, next_pc_s, ras_top_s;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  pc_state_t            state_q, state_d;
  logic                 update_s, ras_empty_s;

  assign pc_plus4_s = pc_q + WIDTH'(PC_STEP);
  assign update_s   = (state_q == ST_RUN) && !halt && !stall;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt) state_d = ST_HALTED;
        else      state_d = ST_RUN;
      end
      ST_HALTED: begin
        if (resume) state_d = ST_RUN;
        else        state_d = ST_HALTED;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // A return only takes the stack target when one exists; otherwise sel decides.
  always_comb begin
    target_s = pc_plus4_s;
    if (pop_ra && !ras_empty_s) begin
      target_s = ras_top_s;
    end else begin
      case (sel)
        PC_SEQ:  target_s = pc_plus4_s;
        PC_BR:   target_s = pc_plus4_s + branch_off;
        PC_J:    target_s = jump_target;
        PC_JR:   target_s = reg_target;
        default: target_s = pc_plus4_s;
      endcase
    end
    next_pc_s = {target_s[WIDTH-1:2], 2'b00};
  end

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (update_s) begin
      pc_d  = next_pc_s;
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_i       (Reset),
    .push_i      (update_s && push_ra),
    .pop_i       (update_s && pop_ra),
    .data_i      (pc_plus4_s),
    .top_o       (ras_top_s),
    .empty_o     (ras_empty_s),
    .full_o      (ras_full),
    .overflow_o  (ras_overflow),
    .underflow_o (ras_underflow)
  );

  assign pc        = pc_q;
  assign pc_plus4  = pc_plus4_s;
  assign ras_top   = ras_top_s;
  assign ras_empty = ras_empty_s;
  assign halted    = (state_q == ST_HALTED);
  assign retired   = cnt_q;

endmodule
